pwm_fifo_sequencer: RTL

Sequencer that drains duty-cycle values from the `sync_fifo` read port and turns each value into exactly one PWM period. It sits between the FIFO and the PWM output pin. It owns the FIFO read strobe and prefetches the next duty value so consecutive periods run back-to-back with no idle cycle. It repeats the last duty and flags an underrun when the FIFO runs dry.

---
 rtl/pwm_fifo_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/pwm_fifo_sequencer.sv
// Drains duty words from a sync FIFO into gapless PWM periods; 2-cycle start latency, next word prefetched one cycle before period end.
// Never reads an empty FIFO: a dry FIFO at prefetch time repeats the last duty and sets a sticky underrun flag.
module pwm_fifo_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_period,
   input  logic [WIDTH-1:0] i_fifo,
   input  logic             i_fifo_empty,
   output logic             o_fifo_re,
   output logic             o_pwm,
   output logic             o_period_done,
   output logic             o_busy,
   output logic             o_underrun
);

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             pf_q, pf_d;
   logic             unr_q, unr_d;
   logic [WIDTH-1:0] per_in;
   logic             can_read;
   logic             at_pre;
   logic             at_last;

   assign per_in   = (i_period == '0) ? WIDTH'(1) : i_period;
   // Reset already forces IDLE; gating here keeps the IDLE read request quiet while reset is held.
   assign can_read = i_rst_n & i_en & ~i_fifo_empty;
   assign at_pre   = (cnt_q == per_q - WIDTH'(1));
   assign at_last  = (cnt_q == per_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= WIDTH'(1);
         duty_q  <= '0;
         pf_q    <= 1'b0;
         unr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         duty_q  <= duty_d;
         pf_q    <= pf_d;
         unr_q   <= unr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_d     = per_q;
      duty_d    = duty_q;
      pf_d      = pf_q;
      unr_d     = unr_q;
      o_fifo_re = 1'b0;
      case (state_q)
         IDLE: begin
            unr_d = 1'b0;
            if (can_read) begin
               o_fifo_re = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            duty_d  = i_fifo;
            per_d   = per_in;
            cnt_d   = '0;
            pf_d    = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            // Strobe one cycle early so the FIFO's registered data lands on the last count.
            if (at_pre && can_read) begin
               o_fifo_re = 1'b1;
               pf_d      = 1'b1;
            end
            if (at_last) begin
               cnt_d = '0;
               pf_d  = 1'b0;
               if (!i_en) begin
                  state_d = IDLE;
                  unr_d   = 1'b0;
               end else begin
                  per_d = per_in;
                  if (pf_q) begin
                     duty_d = i_fifo;
                  end else begin
                     unr_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_pwm         = (state_q == RUN) && (cnt_q < duty_q);
   assign o_period_done = (state_q == RUN) && at_last;
   assign o_busy        = (state_q == LOAD) || (state_q == RUN);
   assign o_underrun    = unr_q;

endmodule
